// File: rtl/camera_proj_scheduler_pkg.sv
// Shared types and default sizes for the camera projection scheduler.
//   coord_t   : signed fixed-point coordinate (opaque to the scheduler)
//   vertex_t  : {z,y,x} vertex, x in the LSBs
//   point2d_t : {y,x} projected point, x in the LSBs
//   cam_cfg_t : packed camera configuration (view/proj matrix words)
//   req_idx_t : requester index for the default requester count
package camera_proj_pkg;

  localparam int unsigned COORD_W          = 16;
  localparam int unsigned CAM_W            = 256;
  localparam int unsigned NUM_REQ_DEF      = 4;
  localparam int unsigned MAX_INFLIGHT_DEF = 8;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t z;
    coord_t y;
    coord_t x;
  } vertex_t;

  typedef struct packed {
    coord_t y;
    coord_t x;
  } point2d_t;

  typedef logic [CAM_W-1:0] cam_cfg_t;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

endpackage

// File: rtl/camera_proj_scheduler_if.sv
// Handshake bundle between the scheduler, its vertex requesters and the
// projection pipeline.
//   req_*      : per-requester vertex request (valid/ready/vertex, req 0 in LSBs)
//   rsp_*      : per-requester projected point return (one-hot valid, shared xy)
//   pipe_in_*  : granted vertex toward the projection pipeline
//   pipe_out_* : projected point from the pipeline
// slave  = scheduler view, master = environment (requesters + pipeline) view.
interface camera_proj_scheduler_if
  import camera_proj_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) ();

  logic    [NUM_REQ-1:0] req_valid;
  logic    [NUM_REQ-1:0] req_ready;
  vertex_t [NUM_REQ-1:0] req_vertex;

  logic    [NUM_REQ-1:0] rsp_valid;
  logic    [NUM_REQ-1:0] rsp_ready;
  point2d_t              rsp_xy;

  logic                  pipe_in_valid;
  logic                  pipe_in_ready;
  vertex_t               pipe_in_vertex;

  logic                  pipe_out_valid;
  logic                  pipe_out_ready;
  point2d_t              pipe_out_xy;

  modport slave (
    input  req_valid, req_vertex, rsp_ready, pipe_in_ready, pipe_out_valid, pipe_out_xy,
    output req_ready, rsp_valid, rsp_xy, pipe_in_valid, pipe_in_vertex, pipe_out_ready
  );

  modport master (
    output req_valid, req_vertex, rsp_ready, pipe_in_ready, pipe_out_valid, pipe_out_xy,
    input  req_ready, rsp_valid, rsp_xy, pipe_in_valid, pipe_in_vertex, pipe_out_ready
  );

endinterface

// File: rtl/camera_proj_scheduler_rr_arbiter.sv
// Round-robin grant selection (purely combinational).
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   gnt_idx   : first requesting index at or after ptr, wrapping NUM_REQ-1 -> 0
//   gnt_valid : any request present
module cam_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int unsigned cand;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_valid && req[IDX_W'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/camera_proj_scheduler.sv
// Shares one in-order camera projection pipeline among NUM_REQ vertex
// requesters. Vertices are granted round-robin, tagged with the requester
// index in a tag FIFO, and pipeline results are routed back in issue order.
// Camera config updates are shadowed and only applied once the pipeline is
// empty.
//   ACLK, ARESET  : clock, synchronous active-high reset
//   bus           : requester / pipeline handshakes (slave modport)
//   cfg_update    : 1-cycle pulse, new config on cfg_cam_in
//   cfg_cam_in    : config from the register bank
//   cfg_cam_out   : config currently driving the pipeline
//   cfg_pending   : update captured, waiting for drain
//   cfg_applied   : 1-cycle pulse when cfg_cam_out changes
//   inflight_cnt  : vertices inside the pipeline
//   err_orphan    : sticky, pipeline result seen with no outstanding tag
module camera_proj_scheduler
  import camera_proj_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  camera_proj_scheduler_if.slave        bus,
  input  logic                          cfg_update,
  input  cam_cfg_t                      cfg_cam_in,
  output cam_cfg_t                      cfg_cam_out,
  output logic                          cfg_pending,
  output logic                          cfg_applied,
  output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt,
  output logic                          err_orphan
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] head;
  logic             gnt_valid;
  logic             room;
  logic             can_issue;
  logic             issue;
  logic             ret;
  logic             fifo_empty;

  logic [IDX_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  cam_cfg_t         shadow;

  cam_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Handshake outputs are combinational from the registered state; they are
  // also forced low while ARESET is asserted so the bus is quiet in reset.
  always_comb begin
    room       = !cfg_pending && (inflight_cnt < CNT_MAX);
    can_issue  = room && bus.pipe_in_ready;
    fifo_empty = (inflight_cnt == '0);
    head       = tag_mem[rd_ptr];

    bus.pipe_in_valid  = !ARESET && gnt_valid && room;
    bus.pipe_in_vertex = bus.req_vertex[gnt_idx];

    bus.req_ready = '0;
    if (!ARESET && gnt_valid && can_issue) bus.req_ready[gnt_idx] = 1'b1;

    bus.rsp_valid = '0;
    if (!ARESET && bus.pipe_out_valid && !fifo_empty) bus.rsp_valid[head] = 1'b1;
    bus.rsp_xy = bus.pipe_out_xy;

    // Head-of-line: a stalled head requester blocks every return behind it.
    bus.pipe_out_ready = !ARESET && !fifo_empty && bus.rsp_ready[head];

    issue = bus.pipe_in_valid && bus.pipe_in_ready;
    ret   = bus.pipe_out_valid && bus.pipe_out_ready;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight_cnt <= '0;
      err_orphan   <= 1'b0;
      shadow       <= '0;
      cfg_cam_out  <= '0;
      cfg_pending  <= 1'b0;
      cfg_applied  <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;

      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
      end
      if (ret) rd_ptr <= rd_ptr + 1'b1;

      case ({issue, ret})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: ;
      endcase

      if (bus.pipe_out_valid && fifo_empty) err_orphan <= 1'b1;

      // A fresh update always wins over apply, so a pulse that lands on the
      // drain cycle delays apply by one cycle and the newest value goes out.
      if (cfg_update) begin
        shadow      <= cfg_cam_in;
        cfg_pending <= 1'b1;
      end else if (cfg_pending && fifo_empty) begin
        cfg_cam_out <= shadow;
        cfg_pending <= 1'b0;
        cfg_applied <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (issue) tag_mem[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_camera_proj_scheduler.sv
module tb_camera_proj_scheduler;
  import camera_proj_pkg::*;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       cfg_update;
  cam_cfg_t   cfg_cam_in;
  cam_cfg_t   cfg_cam_out;
  logic       cfg_pending;
  logic       cfg_applied;
  logic [3:0] inflight_cnt;
  logic       err_orphan;

  int checks   = 0;
  int failures = 0;

  camera_proj_scheduler_if #(.NUM_REQ(4)) bus ();

  camera_proj_scheduler #(.NUM_REQ(4), .MAX_INFLIGHT(8)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .bus          (bus),
    .cfg_update   (cfg_update),
    .cfg_cam_in   (cfg_cam_in),
    .cfg_cam_out  (cfg_cam_out),
    .cfg_pending  (cfg_pending),
    .cfg_applied  (cfg_applied),
    .inflight_cnt (inflight_cnt),
    .err_orphan   (err_orphan)
  );

  always #5 ACLK = ~ACLK;

  localparam cam_cfg_t CFG_A = {8{32'hA5A5_0001}};
  localparam cam_cfg_t CFG_B = {8{32'hB0B0_0002}};
  localparam cam_cfg_t CFG_C = {8{32'hC3C3_0003}};
  localparam cam_cfg_t CFG_D = {8{32'hD4D4_0004}};

  function automatic vertex_t vtx(input int unsigned i);
    vertex_t v;
    v.x = coord_t'(32'h1000 + i);
    v.y = coord_t'(32'h2000 + i);
    v.z = coord_t'(32'h3000 + i);
    return v;
  endfunction

  function automatic logic [3:0] oh(input int unsigned i);
    logic [3:0] r;
    r = 4'b0001 << i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_return(input string tag, input int unsigned req);
    settle();
    chk({tag, "_rsp_valid"}, bus.rsp_valid, oh(req));
    chk({tag, "_pipe_out_ready"}, bus.pipe_out_ready, 1'b1);
    tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 4'b0000);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 4'b0000);
    chk({tag, "_pipe_in_valid"}, bus.pipe_in_valid, 1'b0);
    chk({tag, "_pipe_out_ready"}, bus.pipe_out_ready, 1'b0);
    chk({tag, "_cfg_cam_out"}, cfg_cam_out, '0);
    chk({tag, "_cfg_pending"}, cfg_pending, 1'b0);
    chk({tag, "_cfg_applied"}, cfg_applied, 1'b0);
    chk({tag, "_inflight"}, inflight_cnt, 4'd0);
    chk({tag, "_err_orphan"}, err_orphan, 1'b0);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  point2d_t xy;

  initial begin
    ARESET             = 1'b1;
    cfg_update         = 1'b0;
    cfg_cam_in         = '0;
    bus.req_valid      = '0;
    for (int i = 0; i < 4; i++) bus.req_vertex[i] = vtx(i);
    bus.rsp_ready      = '0;
    bus.pipe_in_ready  = 1'b0;
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_xy    = '0;

    // Reset state
    tick();
    tick();
    settle();
    chk_reset_state("rst");
    ARESET = 1'b0;

    // Single req0 vertex, pipeline latency 3
    bus.req_valid     = 4'b0001;
    bus.pipe_in_ready = 1'b1;
    settle();
    chk("t1_req_ready", bus.req_ready, 4'b0001);
    chk("t1_pipe_in_valid", bus.pipe_in_valid, 1'b1);
    chk("t1_pipe_in_vertex", bus.pipe_in_vertex, vtx(0));
    tick();
    bus.req_valid = '0;
    settle();
    chk("t1_inflight_1", inflight_cnt, 4'd1);
    chk("t1_no_reissue", bus.pipe_in_valid, 1'b0);
    tick();
    tick();
    xy.x = 16'h00AA;
    xy.y = 16'h0055;
    bus.pipe_out_xy    = xy;
    bus.pipe_out_valid = 1'b1;
    bus.rsp_ready      = 4'b1111;
    settle();
    chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t1_rsp_xy", bus.rsp_xy, 32'h0055_00AA);
    chk("t1_pipe_out_ready", bus.pipe_out_ready, 1'b1);
    tick();
    bus.pipe_out_valid = 1'b0;
    settle();
    chk("t1_inflight_0", inflight_cnt, 4'd0);
    chk("t1_rsp_idle", bus.rsp_valid, 4'b0000);

    // All requesters held: round-robin 0,1,2,3,0,... until 8 in flight
    do_reset();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("rr_req_ready_%0d", k), bus.req_ready, oh(k % 4));
      chk($sformatf("rr_vertex_%0d", k), bus.pipe_in_vertex, vtx(k % 4));
      chk($sformatf("rr_inflight_%0d", k), inflight_cnt, 4'(k));
      tick();
    end
    settle();
    chk("full_inflight", inflight_cnt, 4'd8);
    chk("full_req_ready", bus.req_ready, 4'b0000);
    chk("full_pipe_in_valid", bus.pipe_in_valid, 1'b0);
    tick();
    chk("full_hold", inflight_cnt, 4'd8);

    // Near-full: return only, then simultaneous issue+return, then refill
    xy.x = 16'h0123;
    xy.y = 16'h0456;
    bus.pipe_out_xy    = xy;
    bus.pipe_out_valid = 1'b1;
    settle();
    chk("nf_rsp_valid_0", bus.rsp_valid, 4'b0001);
    chk("nf_req_ready_0", bus.req_ready, 4'b0000);
    chk("nf_rsp_xy", bus.rsp_xy, 32'h0456_0123);
    tick();
    settle();
    chk("nf_inflight_7", inflight_cnt, 4'd7);
    chk("nf_rsp_valid_1", bus.rsp_valid, 4'b0010);
    chk("nf_req_ready_1", bus.req_ready, 4'b0001);
    tick();
    settle();
    chk("nf_simul_inflight", inflight_cnt, 4'd7);
    bus.pipe_out_valid = 1'b0;
    settle();
    chk("nf_req_ready_2", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    settle();
    chk("nf_refill_inflight", inflight_cnt, 4'd8);

    // Tag order now 2,3,0,1,2,3,0,1; drain three, then stall requester 1
    bus.pipe_out_valid = 1'b1;
    chk_return("hol_pre0", 2);
    chk_return("hol_pre1", 3);
    chk_return("hol_pre2", 0);
    bus.rsp_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("hol_stall_ready_%0d", k), bus.pipe_out_ready, 1'b0);
      chk($sformatf("hol_stall_valid_%0d", k), bus.rsp_valid, 4'b0010);
      chk($sformatf("hol_stall_inflight_%0d", k), inflight_cnt, 4'd5);
      tick();
    end
    bus.rsp_ready = 4'b1111;
    chk_return("hol_post0", 1);
    chk_return("hol_post1", 2);
    chk_return("hol_post2", 3);
    chk_return("hol_post3", 0);
    chk_return("hol_post4", 1);
    bus.pipe_out_valid = 1'b0;
    settle();
    chk("hol_inflight_0", inflight_cnt, 4'd0);

    // Config update with 3 in flight; A then B while pending
    bus.req_valid = 4'b1111;
    settle();
    chk("cfg_grant_2", bus.req_ready, 4'b0100);
    tick();
    settle();
    chk("cfg_grant_3", bus.req_ready, 4'b1000);
    tick();
    cfg_update = 1'b1;
    cfg_cam_in = CFG_A;
    settle();
    chk("cfg_issue_with_update", bus.req_ready, 4'b0001);
    tick();
    cfg_update = 1'b0;
    settle();
    chk("cfg_pending_set", cfg_pending, 1'b1);
    chk("cfg_inflight_3", inflight_cnt, 4'd3);
    chk("cfg_gate_ready", bus.req_ready, 4'b0000);
    chk("cfg_gate_valid", bus.pipe_in_valid, 1'b0);
    chk("cfg_out_unchanged", cfg_cam_out, '0);
    cfg_update = 1'b1;
    cfg_cam_in = CFG_B;
    tick();
    cfg_update    = 1'b0;
    cfg_cam_in    = '0;
    bus.req_valid = '0;
    bus.pipe_out_valid = 1'b1;
    chk_return("cfg_ret0", 2);
    chk_return("cfg_ret1", 3);
    chk_return("cfg_ret2", 0);
    bus.pipe_out_valid = 1'b0;
    settle();
    chk("cfg_drained", inflight_cnt, 4'd0);
    chk("cfg_still_pending", cfg_pending, 1'b1);
    chk("cfg_out_before_apply", cfg_cam_out, '0);
    chk("cfg_no_applied_yet", cfg_applied, 1'b0);
    tick();
    chk("cfg_out_B", cfg_cam_out, CFG_B);
    chk("cfg_applied_pulse", cfg_applied, 1'b1);
    chk("cfg_pending_clear", cfg_pending, 1'b0);
    tick();
    chk("cfg_applied_low", cfg_applied, 1'b0);
    chk("cfg_out_B_hold", cfg_cam_out, CFG_B);

    // Update landing on the apply cycle defers apply by one cycle
    cfg_update = 1'b1;
    cfg_cam_in = CFG_C;
    tick();
    cfg_update = 1'b0;
    settle();
    chk("def_pending", cfg_pending, 1'b1);
    cfg_update = 1'b1;
    cfg_cam_in = CFG_D;
    tick();
    cfg_update = 1'b0;
    chk("def_still_pending", cfg_pending, 1'b1);
    chk("def_out_B", cfg_cam_out, CFG_B);
    chk("def_no_applied", cfg_applied, 1'b0);
    tick();
    chk("def_out_D", cfg_cam_out, CFG_D);
    chk("def_applied", cfg_applied, 1'b1);
    chk("def_pending_clear", cfg_pending, 1'b0);

    // Orphan result with nothing in flight
    chk("orph_clear", err_orphan, 1'b0);
    bus.pipe_out_valid = 1'b1;
    settle();
    chk("orph_ready_low", bus.pipe_out_ready, 1'b0);
    chk("orph_rsp_none", bus.rsp_valid, 4'b0000);
    tick();
    bus.pipe_out_valid = 1'b0;
    settle();
    chk("orph_set", err_orphan, 1'b1);
    tick();
    tick();
    chk("orph_sticky", err_orphan, 1'b1);

    // Reset in the middle of traffic (pointer currently at 1)
    bus.req_valid = 4'b1111;
    tick();
    tick();
    cfg_update = 1'b1;
    cfg_cam_in = CFG_A;
    settle();
    chk("mid_inflight_2", inflight_cnt, 4'd2);
    tick();
    cfg_update = 1'b0;
    settle();
    chk("mid_inflight_3", inflight_cnt, 4'd3);
    chk("mid_pending", cfg_pending, 1'b1);
    ARESET             = 1'b1;
    bus.req_valid      = '0;
    bus.pipe_out_valid = 1'b1;
    tick();
    settle();
    chk_reset_state("mid_rst");
    ARESET             = 1'b0;
    bus.pipe_out_valid = 1'b0;
    bus.req_valid      = 4'b1111;
    settle();
    chk("mid_rr_ptr_0", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
